// File: rtl/gc_rx_pkg.sv
// gc_rx_pkg: state encoding, default 100 MHz timing constants and majority helper for the joybus receiver
package gc_rx_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, WAIT, STOP} gc_rx_state_e;
  localparam int GC_DEFAULT_BITS = 64;
  localparam int GC_SAMPLE_TICKS_100MHZ = 200;
  localparam int GC_TIMEOUT_TICKS_100MHZ = 1000;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/gc_rx_frame_if.sv
// gc_rx_frame_if: receiver-to-register-block bundle; master is the receiver, slave the consumer
interface gc_rx_frame_if #(parameter int NUM_BITS = 64);
  logic rx_en;
  logic [NUM_BITS-1:0] response;
  logic resp_valid;
  logic frame_err;
  logic busy;
  logic [7:0] bit_count;
  modport master(input rx_en, output response, resp_valid, frame_err, busy, bit_count);
  modport slave(output rx_en, input response, resp_valid, frame_err, busy, bit_count);
endinterface

// File: rtl/gc_rx_sync.sv
// gc_rx_sync: 2-flop pad synchroniser, optional 3-tap majority filter (GC_RX_GLITCH_FILTER_EN), falling-edge detect
module gc_rx_sync
  import gc_rx_pkg::*;
(
  input  logic PCLK,
  input  logic PRESERN,
  input  logic data_in,
  output logic line_s,
  output logic fall
);
  logic [1:0] sync_q, sync_d;
  logic prev_q, prev_d;
`ifdef GC_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;
  always_comb begin
    hist_d = {hist_q[0], sync_q[1]};
    line_s = maj3({hist_q, sync_q[1]});
  end
  always_ff @(posedge PCLK or negedge PRESERN)
    if (!PRESERN) hist_q <= 2'b11;
    else hist_q <= hist_d;
`else
  assign line_s = sync_q[1];
`endif
  always_comb begin
    sync_d = {sync_q[0], data_in};
    prev_d = line_s;
    fall = prev_q & ~line_s;
  end
  // idle line is high, so reset to ones to avoid a false edge out of reset
  always_ff @(posedge PCLK or negedge PRESERN)
    if (!PRESERN) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
endmodule

// File: rtl/gc_rx_frame.sv
// gc_rx_frame: parametrised joybus response receiver with edge-resynchronised sampling and idle timeout
// Optional glitch filter in gc_rx_sync enabled by GC_RX_GLITCH_FILTER_EN.
module gc_rx_frame
  import gc_rx_pkg::*;
#(
  parameter int NUM_BITS = GC_DEFAULT_BITS,
  parameter int SAMPLE_TICKS = GC_SAMPLE_TICKS_100MHZ,
  parameter int TIMEOUT_TICKS = GC_TIMEOUT_TICKS_100MHZ,
  parameter int CNT_W = 12
) (
  input logic PCLK,
  input logic PRESERN,
  input logic data_in,
  gc_rx_frame_if.master bus
);
  gc_rx_state_e state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d, tick_inc, tick_run;
  logic [NUM_BITS-1:0] shift_q, shift_d, shifted, response_q, response_d;
  logic [7:0] count_q, count_d;
  logic valid_q, valid_d, err_q, err_d;
  logic line_s, fall;
  gc_rx_sync u_sync (
    .PCLK(PCLK),
    .PRESERN(PRESERN),
    .data_in(data_in),
    .line_s(line_s),
    .fall(fall)
  );
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    shift_d = shift_q;
    count_d = count_q;
    response_d = response_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    shifted = NUM_BITS'({shift_q, line_s});
    tick_inc = tick_q + 1'b1;
    tick_run = line_s ? tick_inc : '0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        count_d = '0;
        shift_d = '0;
        if (fall) begin
          state_d = SAMPLE;
          tick_d = CNT_W'(1);
        end
      end
      SAMPLE: begin
        tick_d = tick_inc;
        if (tick_q == CNT_W'(SAMPLE_TICKS)) begin
          shift_d = shifted;
          count_d = count_q + 8'd1;
          tick_d = '0;
          state_d = (count_d == 8'(NUM_BITS)) ? STOP : WAIT;
          response_d = (count_d == 8'(NUM_BITS)) ? shifted : response_q;
          valid_d = count_d == 8'(NUM_BITS);
        end
      end
      WAIT: begin
        // a new bit edge beats a simultaneous timeout
        if (fall) begin
          state_d = SAMPLE;
          tick_d = CNT_W'(1);
        end else if (tick_q == CNT_W'(TIMEOUT_TICKS)) begin
          state_d = IDLE;
          tick_d = '0;
          err_d = 1'b1;
        end else tick_d = tick_run;
      end
      STOP: begin
        tick_d = tick_run;
        if (tick_q == CNT_W'(TIMEOUT_TICKS)) begin
          state_d = IDLE;
          tick_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.rx_en) begin
      state_d = IDLE;
      tick_d = '0;
      shift_d = '0;
      count_d = '0;
      response_d = response_q;
      valid_d = 1'b0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge PCLK or negedge PRESERN)
    if (!PRESERN) begin
      state_q <= IDLE;
      tick_q <= '0;
      shift_q <= '0;
      count_q <= '0;
      response_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      shift_q <= shift_d;
      count_q <= count_d;
      response_q <= response_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  assign bus.response = response_q;
  assign bus.resp_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy = state_q != IDLE;
  assign bus.bit_count = count_q;
endmodule

// File: tb/tb_gc_rx_frame.sv
// tb_gc_rx_frame: scoreboard bench for a 64-bit and a 24-bit receiver driven by directed joybus frames
module tb_gc_rx_frame;
  typedef struct packed {
    logic err;
    logic [63:0] data;
  } exp_t;
  logic PCLK = 1'b0;
  logic rst_a_n = 1'b0, rst_b_n = 1'b0;
  logic din_a = 1'b1, din_b = 1'b1;
  int n_checks = 0, n_fail = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  gc_rx_frame_if #(.NUM_BITS(64)) bus_a ();
  gc_rx_frame_if #(.NUM_BITS(24)) bus_b ();
  gc_rx_frame #(.NUM_BITS(64)) dut_a (.PCLK(PCLK), .PRESERN(rst_a_n), .data_in(din_a), .bus(bus_a));
  gc_rx_frame #(.NUM_BITS(24)) dut_b (.PCLK(PCLK), .PRESERN(rst_b_n), .data_in(din_b), .bus(bus_b));
  always #5 PCLK = ~PCLK;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic wait_clks(input int n);
    repeat (n) @(negedge PCLK);
  endtask
  task automatic drive(input int d, input logic v);
    if (d == 0) din_a = v;
    else din_b = v;
  endtask
  task automatic send_bit(input int d, input logic b);
    drive(d, 1'b0);
    wait_clks(b ? 100 : 300);
    drive(d, 1'b1);
    wait_clks(b ? 300 : 100);
  endtask
  task automatic send_bits(input int d, input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d, v[i]);
  endtask
  task automatic check_reset(input int d);
    if (d == 0) begin
      check("a_reset_response", bus_a.response, 64'd0);
      check("a_reset_flags", {bus_a.resp_valid, bus_a.frame_err, bus_a.busy}, 64'd0);
      check("a_reset_bit_count", 64'(bus_a.bit_count), 64'd0);
    end else begin
      check("b_reset_response", 64'(bus_b.response), 64'd0);
      check("b_reset_flags", {bus_b.resp_valid, bus_b.frame_err, bus_b.busy}, 64'd0);
      check("b_reset_bit_count", 64'(bus_b.bit_count), 64'd0);
    end
  endtask
  always @(negedge PCLK)
    if (rst_a_n && (bus_a.resp_valid || bus_a.frame_err)) begin
      if (qa.size() == 0) check("a_unexpected_pulse", {bus_a.resp_valid, bus_a.frame_err}, 64'd0);
      else begin
        ea = qa.pop_front();
        check("a_pulse_kind", {bus_a.resp_valid, bus_a.frame_err}, ea.err ? 64'd1 : 64'd2);
        check("a_response", bus_a.response, ea.data);
        if (ea.err) check("a_busy_at_err", 64'(bus_a.busy), 64'd0);
      end
    end
  always @(negedge PCLK)
    if (rst_b_n && (bus_b.resp_valid || bus_b.frame_err)) begin
      if (qb.size() == 0) check("b_unexpected_pulse", {bus_b.resp_valid, bus_b.frame_err}, 64'd0);
      else begin
        eb = qb.pop_front();
        check("b_pulse_kind", {bus_b.resp_valid, bus_b.frame_err}, eb.err ? 64'd1 : 64'd2);
        check("b_response", 64'(bus_b.response), eb.data);
        if (eb.err) check("b_busy_at_err", 64'(bus_b.busy), 64'd0);
      end
    end
  initial begin
    bus_a.rx_en = 1'b1;
    bus_b.rx_en = 1'b1;
    wait_clks(3);
    fork
      begin
        check_reset(0);
        rst_a_n = 1'b1;
        wait_clks(20);
        send_bits(0, 64'h2B5, 10);
        check("a_mid_bit_count", 64'(bus_a.bit_count), 64'd10);
        check("a_mid_busy", 64'(bus_a.busy), 64'd1);
        #2 rst_a_n = 1'b0;
        #1 check_reset(0);
        wait_clks(3);
        rst_a_n = 1'b1;
        wait_clks(20);
        qa.push_back('{err: 1'b0, data: 64'h8000_0000_0000_0001});
        send_bits(0, 64'h8000_0000_0000_0001, 64);
        send_bit(0, 1'b1);
        wait_clks(900);
        check("a_full_response", bus_a.response, 64'h8000_0000_0000_0001);
        check("a_full_busy", 64'(bus_a.busy), 64'd0);
        qa.push_back('{err: 1'b1, data: 64'h8000_0000_0000_0001});
        send_bits(0, 64'hABCDE, 20);
        check("a_trunc_bit_count", 64'(bus_a.bit_count), 64'd20);
        wait_clks(1100);
        check("a_trunc_response", bus_a.response, 64'h8000_0000_0000_0001);
        check("a_trunc_busy", 64'(bus_a.busy), 64'd0);
        send_bits(0, 64'h2DEA_DBEE, 30);
        check("a_pre_abort_count", 64'(bus_a.bit_count), 64'd30);
        bus_a.rx_en = 1'b0;
        wait_clks(1);
        check("a_abort_busy", 64'(bus_a.busy), 64'd0);
        check("a_abort_bit_count", 64'(bus_a.bit_count), 64'd0);
        send_bits(0, 64'h15, 5);
        check("a_disabled_busy", 64'(bus_a.busy), 64'd0);
        check("a_disabled_bit_count", 64'(bus_a.bit_count), 64'd0);
        wait_clks(1100);
        bus_a.rx_en = 1'b1;
        wait_clks(20);
        check("a_after_enable_response", bus_a.response, 64'h8000_0000_0000_0001);
      end
      begin
        check_reset(1);
        rst_b_n = 1'b1;
        wait_clks(20);
        qb.push_back('{err: 1'b0, data: 64'hA5C3F0});
        send_bits(1, 64'hA5C3F0, 24);
        send_bit(1, 1'b1);
        wait_clks(1000);
        check("b_first_busy", 64'(bus_b.busy), 64'd0);
        qb.push_back('{err: 1'b0, data: 64'h5A3C0F});
        send_bits(1, 64'h5A3C0F, 24);
        send_bit(1, 1'b1);
        wait_clks(1000);
        check("b_second_response", 64'(bus_b.response), 64'h5A3C0F);
        drive(1, 1'b0);
        wait_clks(1);
        drive(1, 1'b1);
`ifdef GC_RX_GLITCH_FILTER_EN
        wait_clks(50);
        check("b_glitch_busy", 64'(bus_b.busy), 64'd0);
        wait_clks(1300);
        check("b_glitch_busy_late", 64'(bus_b.busy), 64'd0);
`else
        qb.push_back('{err: 1'b1, data: 64'h5A3C0F});
        wait_clks(5);
        check("b_glitch_busy", 64'(bus_b.busy), 64'd1);
        wait_clks(1300);
        check("b_glitch_busy_late", 64'(bus_b.busy), 64'd0);
`endif
      end
    join
    wait_clks(10);
    check("a_queue_drained", 64'(qa.size()), 64'd0);
    check("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
